// File: rtl/seq_add_ctrl_pkg.sv
// Shared definitions for the byte-serial add/subtract controller:
// FSM state encoding and the width of one datapath slice.
package seq_add_ctrl_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_add_ctrl_rca.sv
// 8-bit ripple-carry adder slice; also exposes the carry into the MSB
// so the controller can derive signed overflow.
module seq_add_ctrl_rca
  import seq_add_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               c_msb
);

  // Ripple the carry bit by bit; the chain lives in one local variable.
  always_comb begin
    logic [SLICE_W:0] c_v;
    c_v    = '0;
    c_v[0] = cin;
    sum    = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c_v[i];
      c_v[i+1] = (a[i] & b[i]) | (c_v[i] & (a[i] ^ b[i]));
    end
    cout  = c_v[SLICE_W];
    c_msb = c_v[SLICE_W-1];
  end

endmodule

// File: rtl/seq_add_ctrl.sv
// Byte-serial adder/subtractor: one shared 8-bit RCA processes one slice
// per cycle, LSB first, with the slice carry held in a register.
module seq_add_ctrl
  import seq_add_ctrl_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      sub,
  input  logic [SLICE_W*NBYTES-1:0] op_a,
  input  logic [SLICE_W*NBYTES-1:0] op_b,
  output logic                      busy,
  output logic                      done,
  output logic [SLICE_W*NBYTES-1:0] result,
  output logic                      cout,
  output logic                      ovf
);

  localparam int W    = SLICE_W * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  state_t            state_r;
  state_t            state_s;
  logic [IDXW-1:0]   idx_r;
  logic [W-1:0]      a_r;
  logic [W-1:0]      b_r;
  logic [W-1:0]      result_r;
  logic              sub_r;
  logic              carry_r;
  logic              busy_r;
  logic              done_r;
  logic              cout_r;
  logic              ovf_r;
  logic [SLICE_W-1:0] slice_a_s;
  logic [SLICE_W-1:0] slice_b_s;
  logic [SLICE_W-1:0] sum_s;
  logic              cin_s;
  logic              slice_cout_s;
  logic              slice_cmsb_s;
  logic              last_s;

  // Slice selection from the captured operands; B is inverted for subtract.
  always_comb begin
    slice_a_s = a_r[int'(idx_r)*SLICE_W +: SLICE_W];
    slice_b_s = b_r[int'(idx_r)*SLICE_W +: SLICE_W] ^ {SLICE_W{sub_r}};
    cin_s     = (idx_r == '0) ? sub_r : carry_r;
    last_s    = (idx_r == LAST_IDX);
  end

  seq_add_ctrl_rca u_rca (
    .a     (slice_a_s),
    .b     (slice_b_s),
    .cin   (cin_s),
    .sum   (sum_s),
    .cout  (slice_cout_s),
    .c_msb (slice_cmsb_s)
  );

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = DONE;
        else        state_s = RUN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Operand capture, per-slice result write and registered status outputs.
  // done follows the DONE state by one cycle so it is a clean register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r    <= '0;
      a_r      <= '0;
      b_r      <= '0;
      sub_r    <= 1'b0;
      carry_r  <= 1'b0;
      result_r <= '0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_r == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r   <= op_a;
            b_r   <= op_b;
            sub_r <= sub;
            idx_r <= '0;
          end
        end
        RUN: begin
          result_r[int'(idx_r)*SLICE_W +: SLICE_W] <= sum_s;
          carry_r <= slice_cout_s;
          if (last_s) begin
            idx_r  <= '0;
            cout_r <= slice_cout_s;
            ovf_r  <= slice_cmsb_s ^ slice_cout_s;
          end else begin
            idx_r <= idx_r + IDXW'(1);
          end
        end
        DONE:    ;
        default: ;
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign cout   = cout_r;
  assign ovf    = ovf_r;

endmodule

// File: tb/tb_seq_add_ctrl.sv
// Scoreboard bench for seq_add_ctrl at NBYTES = 2, 4 and 8.
module tb_seq_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start2, start4, start8;
  logic        sub2, sub4, sub8;
  logic [15:0] op_a2, op_b2, result2;
  logic [31:0] op_a4, op_b4, result4;
  logic [63:0] op_a8, op_b8, result8;
  logic        busy2, busy4, busy8;
  logic        done2, done4, done8;
  logic        cout2, cout4, cout8;
  logic        ovf2, ovf4, ovf8;

  int total = 0;
  int bad   = 0;
  logic [65:0] q2[$];
  logic [65:0] q4[$];
  logic [65:0] q8[$];

  seq_add_ctrl #(.NBYTES(2)) u_dut2 (.clk(clk), .rst(rst), .start(start2), .sub(sub2),
    .op_a(op_a2), .op_b(op_b2), .busy(busy2), .done(done2), .result(result2), .cout(cout2), .ovf(ovf2));
  seq_add_ctrl #(.NBYTES(4)) u_dut4 (.clk(clk), .rst(rst), .start(start4), .sub(sub4),
    .op_a(op_a4), .op_b(op_b4), .busy(busy4), .done(done4), .result(result4), .cout(cout4), .ovf(ovf4));
  seq_add_ctrl #(.NBYTES(8)) u_dut8 (.clk(clk), .rst(rst), .start(start8), .sub(sub8),
    .op_a(op_a8), .op_b(op_b8), .busy(busy8), .done(done8), .result(result8), .cout(cout8), .ovf(ovf8));

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: {result[63:0], carry out, signed overflow} for an n-byte op.
  function automatic logic [65:0] model(input int n, input logic [63:0] a,
                                        input logic [63:0] b, input logic s);
    int w;
    logic [64:0] mask, aa, bb, full, res;
    logic c, v;
    w    = 8 * n;
    mask = (65'd1 << w) - 65'd1;
    aa   = {1'b0, a} & mask;
    bb   = ({1'b0, b} ^ (s ? mask : 65'd0)) & mask;
    full = aa + bb + {64'd0, s};
    res  = full & mask;
    c    = full[w];
    v    = (aa[w-1] == bb[w-1]) && (res[w-1] != aa[w-1]);
    return {res[63:0], c, v};
  endfunction

  function automatic logic done_of(input int sel);
    case (sel)
      2:       return done2;
      4:       return done4;
      8:       return done8;
      default: return 1'b0;
    endcase
  endfunction

  // Scoreboard consumer: every done pulse pops one expected entry.
  always @(posedge clk) begin
    #1;
    if (done2 === 1'b1) begin
      if (q2.size() == 0) check("done2_unexpected", {65'd0, done2}, 66'd0);
      else check("res2", {48'd0, result2, cout2, ovf2}, q2.pop_front());
    end
    if (done4 === 1'b1) begin
      if (q4.size() == 0) check("done4_unexpected", {65'd0, done4}, 66'd0);
      else check("res4", {32'd0, result4, cout4, ovf4}, q4.pop_front());
    end
    if (done8 === 1'b1) begin
      if (q8.size() == 0) check("done8_unexpected", {65'd0, done8}, 66'd0);
      else check("res8", {result8, cout8, ovf8}, q8.pop_front());
    end
  end

  // One operation from an idle DUT; operands are scrambled after capture.
  task automatic do_op(input int sel, input logic [63:0] a, input logic [63:0] b, input logic s);
    logic seen;
    int   lat;
    @(negedge clk);
    case (sel)
      2: begin op_a2 = a[15:0]; op_b2 = b[15:0]; sub2 = s; start2 = 1'b1; q2.push_back(model(2, a, b, s)); end
      4: begin op_a4 = a[31:0]; op_b4 = b[31:0]; sub4 = s; start4 = 1'b1; q4.push_back(model(4, a, b, s)); end
      8: begin op_a8 = a;       op_b8 = b;       sub8 = s; start8 = 1'b1; q8.push_back(model(8, a, b, s)); end
      default: ;
    endcase
    @(posedge clk);
    #1;
    start2 = 1'b0; start4 = 1'b0; start8 = 1'b0;
    op_a2 = ~op_a2; op_b2 = ~op_b2; sub2 = ~sub2;
    op_a4 = ~op_a4; op_b4 = ~op_b4; sub4 = ~sub4;
    op_a8 = ~op_a8; op_b8 = ~op_b8; sub8 = ~sub8;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      seen = done_of(sel);
    end
    check($sformatf("latency%0d", sel), 66'(lat), 66'(sel + 1));
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic        rs;
    int          dcount;
    rst = 1'b1;
    start2 = 1'b0; start4 = 1'b0; start8 = 1'b0;
    sub2 = 1'b0; sub4 = 1'b0; sub8 = 1'b0;
    op_a2 = '0; op_b2 = '0; op_a4 = '0; op_b4 = '0; op_a8 = '0; op_b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset4", {busy4, done4, cout4, ovf4, result4}, 66'd0);
    check("reset8", {busy8, done8, cout8, ovf8, result8}, 66'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors at NBYTES = 4.
    do_op(4, 64'h0000_00FF, 64'h0000_0001, 1'b0);
    do_op(4, 64'hFFFF_FFFF, 64'h0000_0001, 1'b0);
    do_op(4, 64'h7FFF_FFFF, 64'h0000_0001, 1'b0);
    do_op(4, 64'h8000_0000, 64'h0000_0001, 1'b1);
    do_op(4, 64'h0000_0005, 64'h0000_0007, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("hold4", {busy4, result4, cout4, ovf4}, {1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0});

    // start held high with operands changing every cycle.
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      ra = {32'd0, $urandom};
      rb = {32'd0, $urandom};
      rs = 1'($urandom_range(0, 1));
      op_a4 = ra[31:0]; op_b4 = rb[31:0]; sub4 = rs; start4 = 1'b1;
      if (k % 6 == 0) q4.push_back(model(4, ra, rb, rs));
      @(posedge clk);
      #1;
      check("pipe_busy_done", {64'd0, busy4, done4}, {64'd0, (k % 6) != 5, (k % 6) == 5});
    end
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);

    // Reset during the second RUN cycle aborts the operation.
    @(negedge clk);
    op_a4 = 32'h1122_3344; op_b4 = 32'h0101_0101; sub4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort4", {busy4, done4, cout4, ovf4, result4}, 66'd0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done4) dcount++;
    end
    check("abort_no_done", 66'(dcount), 66'd0);

    // Reset wins over start in the same cycle.
    @(negedge clk);
    rst = 1'b1; start4 = 1'b1;
    @(posedge clk);
    #1;
    check("rst_over_start", {65'd0, busy4}, 66'd0);
    @(negedge clk);
    rst = 1'b0; start4 = 1'b0;
    do_op(4, 64'h1234_5678, 64'h0FED_CBA9, 1'b1);

    // Boundary and random vectors at NBYTES = 2 and 8.
    do_op(2, 64'hFFFF, 64'h0001, 1'b0);
    do_op(2, 64'h7FFF, 64'h0001, 1'b0);
    do_op(2, 64'h8000, 64'h0001, 1'b1);
    do_op(2, 64'h0000, 64'h0001, 1'b1);
    do_op(8, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    do_op(8, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    do_op(8, 64'h8000_0000_0000_0000, 64'h1, 1'b1);
    do_op(8, 64'h0, 64'h1, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      do_op(2, {$urandom, $urandom}, {$urandom, $urandom}, 1'(i % 2));
      do_op(8, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    #1;
    check("queues_empty", 66'(q2.size() + q4.size() + q8.size()), 66'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
